// File: rtl/drm_bus_pipe_slice.sv
// Registered two-direction pipeline for the 32-bit DRM bus stream link.
// Each direction is a cascade of 2-entry skid stages with a saturating beat counter at its output.

module drm_bus_pipe_slice_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data
);

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  ready_q;
    logic                  skid_valid_next;
    logic                  xfer;
    logic                  load;

    assign xfer = up_valid & ready_q;
    assign load = ~main_valid | dn_ready;

    // ready_q is the registered complement of the skid state, so a transfer never lands on a full skid.
    always_comb begin
        skid_valid_next = skid_valid;
        if (load) begin
            skid_valid_next = 1'b0;
        end else if (xfer) begin
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            ready_q    <= ~skid_valid_next;
            if (load) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                end else if (xfer) begin
                    main_valid <= 1'b1;
                    main_data  <= up_data;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (xfer) begin
                skid_data <= up_data;
            end
        end
    end

    assign up_ready = ready_q;
    assign dn_valid = main_valid;
    assign dn_data  = main_data;

endmodule

module drm_bus_pipe_slice_chain #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    logic                  node_valid [NUM_STAGES+1];
    logic                  node_ready [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] node_data  [NUM_STAGES+1];
    logic [CNT_WIDTH-1:0]  cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign node_valid[0]          = s_valid;
    assign node_data[0]           = s_data;
    assign s_ready                = node_ready[0];
    assign node_ready[NUM_STAGES] = m_ready;
    assign m_valid                = node_valid[NUM_STAGES];
    assign m_data                 = node_data[NUM_STAGES];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        drm_bus_pipe_slice_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (node_valid[i]),
            .up_ready (node_ready[i]),
            .up_data  (node_data[i]),
            .dn_valid (node_valid[i+1]),
            .dn_ready (node_ready[i+1]),
            .dn_data  (node_data[i+1])
        );
    end

    // Clear wins over a beat landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt <= '0;
        end else if (node_valid[NUM_STAGES] && m_ready) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign beat_cnt = cnt;

endmodule

module drm_bus_pipe_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  drm_aclk,
    input  logic                  drm_arst,
    input  logic                  s_drm_to_uip_tvalid,
    output logic                  s_drm_to_uip_tready,
    input  logic [DATA_WIDTH-1:0] s_drm_to_uip_tdata,
    output logic                  m_drm_to_uip_tvalid,
    input  logic                  m_drm_to_uip_tready,
    output logic [DATA_WIDTH-1:0] m_drm_to_uip_tdata,
    input  logic                  s_uip_to_drm_tvalid,
    output logic                  s_uip_to_drm_tready,
    input  logic [DATA_WIDTH-1:0] s_uip_to_drm_tdata,
    output logic                  m_uip_to_drm_tvalid,
    input  logic                  m_uip_to_drm_tready,
    output logic [DATA_WIDTH-1:0] m_uip_to_drm_tdata,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  d2u_beat_cnt,
    output logic [CNT_WIDTH-1:0]  u2d_beat_cnt
);

    drm_bus_pipe_slice_chain #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_STAGES(NUM_STAGES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_d2u (
        .clk       (drm_aclk),
        .rst       (drm_arst),
        .s_valid   (s_drm_to_uip_tvalid),
        .s_ready   (s_drm_to_uip_tready),
        .s_data    (s_drm_to_uip_tdata),
        .m_valid   (m_drm_to_uip_tvalid),
        .m_ready   (m_drm_to_uip_tready),
        .m_data    (m_drm_to_uip_tdata),
        .cnt_clear (cnt_clear),
        .beat_cnt  (d2u_beat_cnt)
    );

    drm_bus_pipe_slice_chain #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_STAGES(NUM_STAGES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_u2d (
        .clk       (drm_aclk),
        .rst       (drm_arst),
        .s_valid   (s_uip_to_drm_tvalid),
        .s_ready   (s_uip_to_drm_tready),
        .s_data    (s_uip_to_drm_tdata),
        .m_valid   (m_uip_to_drm_tvalid),
        .m_ready   (m_uip_to_drm_tready),
        .m_data    (m_uip_to_drm_tdata),
        .cnt_clear (cnt_clear),
        .beat_cnt  (u2d_beat_cnt)
    );

endmodule

// File: tb/tb_drm_bus_pipe_slice.sv
// Directed bench for drm_bus_pipe_slice: three instances (2, 4 and 1 stages; the last with a
// 4-bit counter) run the same phase sequence, each lane checked by an in-order scoreboard.

module tb_drm_bus_pipe_slice;

    logic        clk;
    logic        rst;
    logic        s_valid [3][2];
    logic        s_ready [3][2];
    logic [31:0] s_data  [3][2];
    logic        m_valid [3][2];
    logic        m_ready [3][2];
    logic [31:0] m_data  [3][2];
    logic [15:0] cnt     [3][2];
    logic        clr     [3];

    int          checks;
    int          failures;
    int          cyc;
    int          sent      [3][2];
    int          rcvd      [3][2];
    int          want      [3][2];
    int          total     [3][2];
    int          first_in  [3][2];
    int          first_out [3][2];
    logic [31:0] base      [3][2];
    int          vmode     [2];
    int          rmode     [2];
    bit          bubble    [2];
    int          rdy_at    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        localparam int CW = (g == 2) ? 4 : 16;
        logic [CW-1:0] c_d2u;
        logic [CW-1:0] c_u2d;
        drm_bus_pipe_slice #(
            .DATA_WIDTH(32),
            .NUM_STAGES(NS),
            .CNT_WIDTH (CW)
        ) u_dut (
            .drm_aclk            (clk),
            .drm_arst            (rst),
            .s_drm_to_uip_tvalid (s_valid[g][0]),
            .s_drm_to_uip_tready (s_ready[g][0]),
            .s_drm_to_uip_tdata  (s_data[g][0]),
            .m_drm_to_uip_tvalid (m_valid[g][0]),
            .m_drm_to_uip_tready (m_ready[g][0]),
            .m_drm_to_uip_tdata  (m_data[g][0]),
            .s_uip_to_drm_tvalid (s_valid[g][1]),
            .s_uip_to_drm_tready (s_ready[g][1]),
            .s_uip_to_drm_tdata  (s_data[g][1]),
            .m_uip_to_drm_tvalid (m_valid[g][1]),
            .m_uip_to_drm_tready (m_ready[g][1]),
            .m_uip_to_drm_tdata  (m_data[g][1]),
            .cnt_clear           (clr[g]),
            .d2u_beat_cnt        (c_d2u),
            .u2d_beat_cnt        (c_u2d)
        );
        assign cnt[g][0] = 16'(c_d2u);
        assign cnt[g][1] = 16'(c_u2d);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ns_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    endfunction

    function automatic int sat_of(input int g);
        return (g == 2) ? 15 : 65535;
    endfunction

    function automatic int exp_cnt(input int g, input int d);
        return (total[g][d] > sat_of(g)) ? sat_of(g) : total[g][d];
    endfunction

    task automatic chk(input string tag, input int g, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d dir=%0d observed=0x%0h expected=0x%0h", tag, g, d, obs, exp);
        end
    endtask

    task automatic drive();
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                s_valid[g][d] = (sent[g][d] < want[g][d]) &&
                                (vmode[d] == 0 || $urandom_range(0, 1) == 1);
                s_data[g][d]  = base[g][d] + 32'(sent[g][d]);
                if (rmode[d] == 0)      m_ready[g][d] = 1'b1;
                else if (rmode[d] == 1) m_ready[g][d] = 1'b0;
                else                    m_ready[g][d] = ($urandom_range(0, 1) == 1);
            end
        end
    endtask

    // Account for the transfers the coming edge will perform, then advance one cycle.
    task automatic tick();
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    if (bubble[d] && rcvd[g][d] > 0 && rcvd[g][d] < want[g][d]) begin
                        chk("no_bubble_m_valid", g, d, 32'(m_valid[g][d]), 32'd1);
                    end
                    if (bubble[d] && sent[g][d] > 0 && sent[g][d] < want[g][d]) begin
                        chk("no_stall_s_ready", g, d, 32'(s_ready[g][d]), 32'd1);
                    end
                    if (s_valid[g][d] && s_ready[g][d]) begin
                        if (sent[g][d] == 0) first_in[g][d] = cyc;
                        sent[g][d]++;
                    end
                    if (m_valid[g][d] && m_ready[g][d]) begin
                        if (rcvd[g][d] == 0) first_out[g][d] = cyc;
                        chk("order_data", g, d, m_data[g][d], base[g][d] + 32'(rcvd[g][d]));
                        rcvd[g][d]++;
                    end
                    if (clr[g]) total[g][d] = 0;
                    else if (m_valid[g][d] && m_ready[g][d]) total[g][d]++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < 3; g++) clr[g] = 1'b0;
        drive();
    endtask

    task automatic new_phase(input int d, input logic [31:0] b, input int n);
        for (int g = 0; g < 3; g++) begin
            base[g][d]      = b + 32'(g << 16);
            want[g][d]      = n;
            sent[g][d]      = 0;
            rcvd[g][d]      = 0;
            first_in[g][d]  = -1;
            first_out[g][d] = -1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int g = 0; g < 3; g++) begin
            clr[g] = 1'b0;
            for (int d = 0; d < 2; d++) total[g][d] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            vmode[d]  = 0;
            rmode[d]  = 0;
            bubble[d] = 1'b0;
            new_phase(d, 32'h0, 0);
        end
        drive();
        repeat (3) tick();

        // Reset state.
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                chk("rst_s_ready", g, d, 32'(s_ready[g][d]), 32'd0);
                chk("rst_m_valid", g, d, 32'(m_valid[g][d]), 32'd0);
                chk("rst_m_data",  g, d, m_data[g][d], 32'd0);
                chk("rst_cnt",     g, d, 32'(cnt[g][d]), 32'd0);
            end
        end
        rst = 1'b0;
        tick();
        for (int g = 0; g < 3; g++)
            for (int d = 0; d < 2; d++)
                chk("s_ready_after_rst", g, d, 32'(s_ready[g][d]), 32'd1);

        // Continuous streaming of 1, 2, 3, ... on both directions.
        for (int d = 0; d < 2; d++) begin
            new_phase(d, 32'h1, 100);
            bubble[d] = 1'b1;
        end
        drive();
        repeat (110) tick();
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                chk("stream_count", g, d, 32'(rcvd[g][d]), 32'd100);
                chk("stream_latency", g, d, 32'(first_out[g][d] - first_in[g][d]), 32'(ns_of(g)));
                chk("stream_cnt", g, d, 32'(cnt[g][d]), (g == 2) ? 32'd15 : 32'd100);
            end
        end

        // Full stall on drm_to_uip while uip_to_drm keeps streaming.
        bubble[0] = 1'b0;
        rmode[0]  = 1;
        new_phase(0, 32'hA0, 16);
        new_phase(1, 32'h1000, 60);
        drive();
        repeat (20) tick();
        for (int g = 0; g < 3; g++) begin
            chk("stall_accepted", g, 0, 32'(sent[g][0]), 32'(2 * ns_of(g)));
            chk("stall_s_ready",  g, 0, 32'(s_ready[g][0]), 32'd0);
            chk("stall_m_valid",  g, 0, 32'(m_valid[g][0]), 32'd1);
            chk("stall_head",     g, 0, m_data[g][0], base[g][0]);
            rdy_at[g] = 0;
        end
        rmode[0] = 0;
        drive();
        for (int k = 1; k <= 6; k++) begin
            tick();
            for (int g = 0; g < 3; g++)
                if (rdy_at[g] == 0 && s_ready[g][0]) rdy_at[g] = k;
        end
        for (int g = 0; g < 3; g++)
            chk("stall_ready_recover", g, 0,
                32'(rdy_at[g] > 0 && rdy_at[g] <= ns_of(g) + 1), 32'd1);
        repeat (40) tick();
        for (int g = 0; g < 3; g++) begin
            chk("stall_drained", g, 0, 32'(rcvd[g][0]), 32'd16);
            chk("other_dir_count", g, 1, 32'(rcvd[g][1]), 32'd60);
            for (int d = 0; d < 2; d++)
                chk("stall_cnt", g, d, 32'(cnt[g][d]), 32'(exp_cnt(g, d)));
        end

        // Clear the counters, then random valid and backpressure.
        bubble[1] = 1'b0;
        for (int g = 0; g < 3; g++) clr[g] = 1'b1;
        tick();
        for (int g = 0; g < 3; g++)
            for (int d = 0; d < 2; d++)
                chk("clear_idle", g, d, 32'(cnt[g][d]), 32'd0);
        for (int d = 0; d < 2; d++) begin
            new_phase(d, 32'h00100000 + 32'(d << 12), 1000000);
            vmode[d] = 2;
            rmode[d] = 2;
        end
        drive();
        repeat (4000) tick();
        for (int g = 0; g < 3; g++)
            for (int d = 0; d < 2; d++) want[g][d] = sent[g][d];
        for (int d = 0; d < 2; d++) begin
            vmode[d] = 0;
            rmode[d] = 0;
        end
        drive();
        repeat (20) tick();
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                chk("rand_lossless", g, d, 32'(rcvd[g][d]), 32'(sent[g][d]));
                chk("rand_traffic", g, d, 32'(sent[g][d] > 500), 32'd1);
                chk("rand_cnt", g, d, 32'(cnt[g][d]),
                    (g == 2) ? 32'd15 : 32'(rcvd[g][d]));
            end
        end

        // Clear coinciding with a delivered beat.
        for (int d = 0; d < 2; d++) new_phase(d, 32'h3000, 50);
        drive();
        repeat (10) tick();
        for (int g = 0; g < 3; g++) begin
            chk("beat_at_clear", g, 0, 32'(m_valid[g][0] & m_ready[g][0]), 32'd1);
            clr[g] = 1'b1;
        end
        tick();
        for (int g = 0; g < 3; g++)
            for (int d = 0; d < 2; d++)
                chk("clear_with_beat", g, d, 32'(cnt[g][d]), 32'd0);
        tick();
        for (int g = 0; g < 3; g++)
            for (int d = 0; d < 2; d++)
                chk("count_after_clear", g, d, 32'(cnt[g][d]), 32'd1);
        repeat (50) tick();

        // Reset with words in flight.
        for (int d = 0; d < 2; d++) begin
            new_phase(d, 32'h7000, 30);
            rmode[d] = 1;
        end
        drive();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                chk("midrst_m_valid", g, d, 32'(m_valid[g][d]), 32'd0);
                chk("midrst_cnt",     g, d, 32'(cnt[g][d]), 32'd0);
                chk("midrst_s_ready", g, d, 32'(s_ready[g][d]), 32'd0);
                total[g][d] = 0;
            end
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            new_phase(d, 32'h9000, 20);
            rmode[d] = 0;
        end
        drive();
        repeat (30) tick();
        for (int g = 0; g < 3; g++) begin
            for (int d = 0; d < 2; d++) begin
                chk("post_rst_count", g, d, 32'(rcvd[g][d]), 32'd20);
                chk("post_rst_cnt", g, d, 32'(cnt[g][d]), (g == 2) ? 32'd15 : 32'd20);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
